// File: rtl/mux_serialiser_if.sv
// Word-in / bit-out bus of the parallel-to-serial stage.
// The slave modport is the serialiser's view of the bus; master is its environment.
interface mux_serialiser_if #(
  parameter int N = 16
);
  localparam int SW = $clog2(N);

  logic          load;
  logic [N-1:0]  din;
  logic          ready;
  logic          dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          last;
  logic [SW-1:0] sel;

  modport slave (
    input  load, din, dout_ready,
    output ready, dout, dout_valid, last, sel
  );

  modport master (
    output load, din, dout_ready,
    input  ready, dout, dout_valid, last, sel
  );
endinterface

// File: rtl/mux_serialiser.sv
// Parallel-to-serial stage: captures an N-bit word, then walks the N:1 mux
// select across it, presenting one bit per accepted valid/ready beat.
module mux_serialiser #(
  parameter int N         = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic             clk,
  input logic             n_reset,
  mux_serialiser_if.slave bus
);
  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] FIRST_IDX = MSB_FIRST ? SW'(N - 1) : SW'(0);
  localparam logic [SW-1:0] LAST_IDX  = MSB_FIRST ? SW'(0) : SW'(N - 1);
  localparam logic [SW-1:0] STEP      = SW'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state_r, state_s;
  logic [N-1:0]  word_r, word_s;
  logic [SW-1:0] sel_r, sel_s;

  // Next-state logic: capture in IDLE, step the select on each SHIFT handshake.
  always_comb begin
    state_s = state_r;
    word_s  = word_r;
    sel_s   = sel_r;
    case (state_r)
      IDLE: begin
        if (bus.load) begin
          word_s  = bus.din;
          sel_s   = FIRST_IDX;
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (bus.dout_ready) begin
          if (sel_r == LAST_IDX) begin
            // Rewinding here keeps sel inside 0..N-1 even for non-power-of-two N.
            state_s = IDLE;
            sel_s   = FIRST_IDX;
          end else if (MSB_FIRST) begin
            sel_s = sel_r - STEP;
          end else begin
            sel_s = sel_r + STEP;
          end
        end else begin
          state_s = SHIFT;
        end
      end
      default: begin
        state_s = IDLE;
        word_s  = {N{1'b0}};
        sel_s   = FIRST_IDX;
      end
    endcase
  end

  // State register with synchronous active-low reset discarding any partial word.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_r <= IDLE;
      word_r  <= {N{1'b0}};
      sel_r   <= FIRST_IDX;
    end else begin
      state_r <= state_s;
      word_r  <= word_s;
      sel_r   <= sel_s;
    end
  end

  assign bus.ready      = n_reset && (state_r == IDLE);
  assign bus.dout_valid = (state_r == SHIFT);
  assign bus.last       = (state_r == SHIFT) && (sel_r == LAST_IDX);
  assign bus.sel        = sel_r;
  assign bus.dout       = word_r[sel_r];
endmodule

// File: tb/tb_mux_serialiser.sv
// Bench for mux_serialiser: LSB-first, MSB-first and a 10-bit instance, driven from
// a vector table with a beat scoreboard, plus reset and mid-word reset sequences.
module tb_mux_serialiser;
  logic clk = 1'b0;
  logic n_reset;
  logic dready;

  always #5 clk = ~clk;

  mux_serialiser_if #(.N(16)) if0 ();
  mux_serialiser_if #(.N(16)) if1 ();
  mux_serialiser_if #(.N(10)) if2 ();

  assign if0.dout_ready = dready;
  assign if1.dout_ready = dready;
  assign if2.dout_ready = dready;

  mux_serialiser #(.N(16), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .n_reset(n_reset), .bus(if0));
  mux_serialiser #(.N(16), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .n_reset(n_reset), .bus(if1));
  mux_serialiser #(.N(10), .MSB_FIRST(1'b0)) u_ten (.clk(clk), .n_reset(n_reset), .bus(if2));

  typedef struct packed {
    logic       d;
    logic [3:0] s;
    logic       l;
  } beat_t;

  // stream[j] is the bit expected on the j-th beat
  typedef struct {
    int          dut;
    logic [15:0] din;
    logic [15:0] stream;
    int          stall_sel;
    int          stall_len;
    bit          midload;
    int          exp_cyc;
  } vec_t;

  beat_t q0[$];
  beat_t q1[$];
  beat_t q2[$];
  vec_t  vt[7];
  int    checks = 0;
  int    passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  function automatic logic g_ready(input int d);
    case (d)
      0: return if0.ready;
      1: return if1.ready;
      2: return if2.ready;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic g_valid(input int d);
    case (d)
      0: return if0.dout_valid;
      1: return if1.dout_valid;
      2: return if2.dout_valid;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic g_dout(input int d);
    case (d)
      0: return if0.dout;
      1: return if1.dout;
      2: return if2.dout;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic g_last(input int d);
    case (d)
      0: return if0.last;
      1: return if1.last;
      2: return if2.last;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] g_sel(input int d);
    case (d)
      0: return if0.sel;
      1: return if1.sel;
      2: return if2.sel;
      default: return 4'h0;
    endcase
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return 0;
    endcase
  endfunction

  task automatic set_in(input int d, input logic ld, input logic [15:0] dn);
    case (d)
      0: begin if0.load = ld; if0.din = dn; end
      1: begin if1.load = ld; if1.din = dn; end
      2: begin if2.load = ld; if2.din = dn[9:0]; end
      default: ;
    endcase
  endtask

  task automatic push_beat(input int d, input beat_t b);
    case (d)
      0: q0.push_back(b);
      1: q1.push_back(b);
      2: q2.push_back(b);
      default: ;
    endcase
  endtask

  task automatic check_beat(input int d);
    beat_t b;
    if (qsize(d) == 0) begin
      checks++;
      $display("FAIL unexpected_beat dut%0d: got a beat with sel %0d, required none", d, g_sel(d));
    end else begin
      case (d)
        0: b = q0.pop_front();
        1: b = q1.pop_front();
        default: b = q2.pop_front();
      endcase
      chk($sformatf("beat_dout_dut%0d", d), g_dout(d), b.d);
      chk($sformatf("beat_sel_dut%0d", d), g_sel(d), b.s);
      chk($sformatf("beat_last_dut%0d", d), g_last(d), b.l);
    end
  endtask

  // Scoreboard monitor: every handshaken beat is popped and compared.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++)
      if (g_valid(d) === 1'b1 && dready === 1'b1) check_beat(d);
  end

  task automatic run_vec(input vec_t v);
    int    n;
    int    c;
    int    j;
    int    stall_left;
    bit    stalled;
    beat_t b;
    n = (v.dut == 2) ? 10 : 16;
    for (int k = 0; k < n; k++) begin
      b.d = v.stream[k];
      b.s = 4'((v.dut == 1) ? (n - 1 - k) : k);
      b.l = (k == n - 1);
      push_beat(v.dut, b);
    end
    chk("idle_ready", g_ready(v.dut), 1);
    set_in(v.dut, 1'b1, v.din);
    @(posedge clk); #1;
    set_in(v.dut, 1'b0, 16'h0000);
    c = 1;
    stall_left = 0;
    stalled = 1'b0;
    while (!g_ready(v.dut) && c < 64) begin
      if (!stalled && v.stall_len > 0 && g_valid(v.dut) && g_sel(v.dut) == 4'(v.stall_sel)) begin
        stalled = 1'b1;
        stall_left = v.stall_len;
      end
      if (stall_left > 0) begin
        if (stall_left < v.stall_len) begin
          j = (v.dut == 1) ? (n - 1 - v.stall_sel) : v.stall_sel;
          chk("hold_sel", g_sel(v.dut), 4'(v.stall_sel));
          chk("hold_valid", g_valid(v.dut), 1);
          chk("hold_dout", g_dout(v.dut), v.stream[j]);
        end
        if (v.midload && stall_left == v.stall_len) set_in(v.dut, 1'b1, 16'h0000);
        dready = 1'b0;
        stall_left--;
      end else begin
        dready = 1'b1;
      end
      @(posedge clk); #1;
      set_in(v.dut, 1'b0, 16'h0000);
      c++;
    end
    dready = 1'b1;
    chk($sformatf("word_cycles_dut%0d", v.dut), c, v.exp_cyc);
    chk($sformatf("sb_empty_dut%0d", v.dut), qsize(v.dut), 0);
  endtask

  initial begin
    int c;
    int bad;
    beat_t b;
    //        dut  din       stream    ssel len mid  cycles
    vt[0] = '{0, 16'hCCAA, 16'hCCAA, -1, 0, 1'b0, 17};
    vt[1] = '{1, 16'hCCAA, 16'h5533, -1, 0, 1'b0, 17};
    vt[2] = '{0, 16'hCCAA, 16'hCCAA,  5, 3, 1'b1, 20};
    vt[3] = '{2, 16'h02B5, 16'h02B5, -1, 0, 1'b0, 11};
    vt[4] = '{1, 16'hCCAA, 16'h5533,  5, 2, 1'b1, 19};
    vt[5] = '{0, 16'h8001, 16'h8001, -1, 0, 1'b0, 17};
    vt[6] = '{2, 16'h0155, 16'h0155,  9, 1, 1'b1, 12};

    n_reset = 1'b0;
    dready  = 1'b1;
    for (int d = 0; d < 3; d++) set_in(d, 1'b1, 16'hFFFF);
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_ready", g_ready(d), 0);
      chk("rst_valid", g_valid(d), 0);
      chk("rst_dout", g_dout(d), 0);
      chk("rst_sel", g_sel(d), (d == 1) ? 15 : 0);
    end
    @(posedge clk); #1;
    n_reset = 1'b1;
    for (int d = 0; d < 3; d++) set_in(d, 1'b0, 16'h0000);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rel_ready", g_ready(d), 1);
      chk("rel_valid", g_valid(d), 0);
    end
    @(posedge clk); #1;

    foreach (vt[i]) run_vec(vt[i]);

    // Reset in the middle of a word at sel=7.
    for (int k = 0; k < 16; k++) begin
      b.d = 1'b1;
      b.s = 4'(k);
      b.l = (k == 15);
      q0.push_back(b);
    end
    set_in(0, 1'b1, 16'hFFFF);
    @(posedge clk); #1;
    set_in(0, 1'b0, 16'h0000);
    c = 0;
    while (g_sel(0) != 4'd7 && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    chk("reach_sel7", g_sel(0), 7);
    n_reset = 1'b0;
    @(posedge clk); #1;
    q0.delete();
    chk("midrst_valid", g_valid(0), 0);
    chk("midrst_dout", g_dout(0), 0);
    chk("midrst_sel", g_sel(0), 0);
    chk("midrst_ready", g_ready(0), 0);
    n_reset = 1'b1;
    #1;
    chk("midrst_rel_ready", g_ready(0), 1);
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (g_valid(0) !== 1'b0) bad++;
    end
    chk("no_beats_after_reset", bad, 0);

    run_vec(vt[0]);
    run_vec(vt[3]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
